// File: rtl/ex_mem_branch_stage_pkg.sv
// ex_mem_branch_stage_pkg: shared branch opcodes, squash FSM states and datapath width
package ex_mem_branch_stage_pkg;
  localparam int DEFAULT_DATA_W = 32;
  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLTZ = 3'd2,
    BGEZ = 3'd3,
    BGTZ = 3'd4,
    BLEZ = 3'd5
  } br_op_t;
  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } state_t;
endpackage

// File: rtl/ex_mem_branch_stage_cond.sv
// br_cond_eval: resolves a branch condition from the subtractor zero/neg flags
module br_cond_eval
  import ex_mem_branch_stage_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic       zero,
  input  logic       neg,
  output logic       cond
);
  always_comb cond = br_op == BEQ  ? zero :
                     br_op == BNE  ? !zero :
                     br_op == BLTZ ? neg :
                     br_op == BGEZ ? !neg :
                     br_op == BGTZ ? (!neg && !zero) :
                     br_op == BLEZ ? (neg || zero) : 1'b0;
endmodule

// File: rtl/ex_mem_branch_stage.sv
// ex_mem_branch_stage: EX->MEM register with branch resolution, PC redirect and wrong-path squash
module ex_mem_branch_stage
  import ex_mem_branch_stage_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int SQUASH_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sub_result,
  input  logic              sub_zero,
  input  logic              sub_neg,
  input  logic              is_branch,
  input  logic [2:0]        br_op,
  input  logic [DATA_W-1:0] br_target,
  input  logic [4:0]        rd_addr,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [DATA_W-1:0] out_store_data,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc
);
  localparam int CW = SQUASH_N > 1 ? $clog2(SQUASH_N + 1) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic cond, accept, squash_active, taken, keep;
  br_cond_eval u_cond (
    .br_op(br_op),
    .zero (sub_zero),
    .neg  (sub_neg),
    .cond (cond)
  );
  assign in_ready      = !mem_stall;
  assign accept        = in_valid && in_ready;
  assign squash_active = state == SQUASH;
  assign taken         = accept && is_branch && cond && !squash_active;
  assign keep          = in_valid && !squash_active;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (taken && SQUASH_N != 0) begin
      state_n = SQUASH;
      cnt_n   = CW'(SQUASH_N);
    end else if (squash_active && !mem_stall) begin
      cnt_n   = cnt - CW'(1);
      state_n = cnt == CW'(1) ? IDLE : SQUASH;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_rd         <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_store_data <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= taken;
      if (taken) redirect_pc <= br_target;
      if (!mem_stall) begin
        out_valid      <= keep;
        out_result     <= sub_result;
        out_rd         <= rd_addr;
        out_reg_write  <= keep && reg_write;
        out_mem_read   <= keep && mem_read;
        out_mem_write  <= keep && mem_write;
        out_store_data <= store_data;
      end
    end
endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// tb_ex_mem_branch_stage: directed and random checks of ex_mem_branch_stage against a slot-counting model
module tb_ex_mem_branch_stage;
  localparam int SQ_N = 2;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub_zero, sub_neg, is_branch;
  logic [31:0] sub_result, br_target, store_data;
  logic [2:0]  br_op;
  logic [4:0]  rd_addr;
  logic        reg_write, mem_read, mem_write, mem_stall;
  logic        out_valid, out_reg_write, out_mem_read, out_mem_write, redirect_valid;
  logic [31:0] out_result, out_store_data, redirect_pc;
  logic [4:0]  out_rd;
  int          errors = 0, checks = 0;
  int          left;
  bit          e_valid, e_rw, e_mr, e_mw, e_redir;
  logic [31:0] e_result, e_sd, e_pc;
  logic [4:0]  e_rd;
  ex_mem_branch_stage #(.DATA_W(32), .SQUASH_N(SQ_N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sub_result(sub_result), .sub_zero(sub_zero), .sub_neg(sub_neg),
    .is_branch(is_branch), .br_op(br_op), .br_target(br_target),
    .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .store_data(store_data), .mem_stall(mem_stall),
    .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_store_data(out_store_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit cond_ref(input int op, input bit z, input bit n);
    case (op)
      0: return z;
      1: return !z;
      2: return n;
      3: return !n;
      4: return !n && !z;
      5: return n || z;
      default: return 1'b0;
    endcase
  endfunction
  task automatic model_reset();
    left = 0;
    {e_valid, e_rw, e_mr, e_mw, e_redir} = '0;
    e_result = '0;
    e_sd = '0;
    e_pc = '0;
    e_rd = '0;
  endtask
  task automatic check_outs(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, ".rw"}, 32'(out_reg_write), 32'(e_rw));
    chk({tag, ".mr"}, 32'(out_mem_read), 32'(e_mr));
    chk({tag, ".mw"}, 32'(out_mem_write), 32'(e_mw));
    chk({tag, ".redir"}, 32'(redirect_valid), 32'(e_redir));
    chk({tag, ".pc"}, redirect_pc, e_pc);
    if (e_valid) begin
      chk({tag, ".result"}, out_result, e_result);
      chk({tag, ".rd"}, 32'(out_rd), 32'(e_rd));
      chk({tag, ".sd"}, out_store_data, e_sd);
    end
  endtask
  task automatic step(input string tag, input bit v, input bit br, input int op,
                      input logic [31:0] a, input logic [31:0] b, input bit stall,
                      input bit rw, input logic [31:0] tgt);
    logic [31:0] d;
    bit sq, tk;
    d = a - b;
    in_valid = v;
    is_branch = br;
    br_op = 3'(op);
    sub_result = d;
    sub_zero = d == 0;
    sub_neg = d[31];
    br_target = tgt;
    rd_addr = 5'($urandom);
    reg_write = rw;
    mem_read = 1'($urandom);
    mem_write = !mem_read && 1'($urandom);
    store_data = $urandom;
    mem_stall = stall;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!stall));
    @(posedge clk);
    if (!stall) begin
      sq = left != 0;
      tk = v && br && cond_ref(op, d == 0, d[31]) && !sq;
      e_valid = v && !sq;
      e_result = d;
      e_rd = rd_addr;
      e_sd = store_data;
      e_rw = e_valid && rw;
      e_mr = e_valid && mem_read;
      e_mw = e_valid && mem_write;
      if (sq) left--;
      else if (tk) left = SQ_N;
      e_redir = tk;
      if (tk) e_pc = tgt;
    end else e_redir = 1'b0;
    #1;
    check_outs(tag);
  endtask
  initial begin
    rst = 1'b1;
    {in_valid, is_branch, reg_write, mem_read, mem_write, mem_stall} = '0;
    {sub_zero, sub_neg} = '0;
    br_op = '0;
    sub_result = '0;
    br_target = '0;
    store_data = '0;
    rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    @(negedge clk);
    rst = 1'b0;
    step("add0", 1, 0, 0, 32'd9, 32'd4, 0, 1, 0);
    step("add1", 1, 0, 0, 32'd7, 32'd2, 0, 1, 0);
    chk("pre_rst.valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    step("beq", 1, 1, 0, 32'd5, 32'd5, 0, 0, 32'h0040_0100);
    chk("beq.pulse", 32'(redirect_valid), 32'd1);
    chk("beq.pc", redirect_pc, 32'h0040_0100);
    step("add_a", 1, 0, 0, 32'd3, 32'd1, 0, 1, 0);
    chk("beq.one_cycle", 32'(redirect_valid), 32'd0);
    step("add_b", 1, 0, 0, 32'd3, 32'd1, 0, 1, 0);
    step("add_c", 1, 0, 0, 32'd3, 32'd1, 0, 1, 0);
    chk("add_c.valid", 32'(out_valid), 32'd1);
    step("bne_t", 1, 1, 1, 32'd8, 32'd1, 0, 0, 32'h1000_0000);
    for (int i = 0; i < 4; i++) step("stall", 1, 0, 0, 32'd2, 32'd1, 1, 1, 0);
    step("res_a", 1, 1, 1, 32'd8, 32'd1, 0, 1, 32'h2000_0000);
    chk("sq_bne.redir", 32'(redirect_valid), 32'd0);
    step("res_b", 1, 0, 0, 32'd2, 32'd1, 0, 1, 0);
    step("res_c", 1, 0, 0, 32'd2, 32'd1, 0, 1, 0);
    chk("res_c.valid", 32'(out_valid), 32'd1);
    step("bltz", 1, 1, 2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'h0000_0abc);
    chk("bltz.taken", 32'(redirect_valid), 32'd1);
    step("drain", 0, 0, 0, 0, 0, 0, 0, 0);
    step("drain", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int op = 0; op < 8; op++)
      for (int f = 0; f < 3; f++) begin
        logic [31:0] bb;
        bb = f == 0 ? 32'd3 : f == 1 ? 32'd4 : 32'd5;
        step("table", 1, 1, op, 32'd4, bb, 0, 0, 32'(op * 16 + f + 32'h100));
        step("tdrain", 0, 0, 0, 0, 0, 0, 0, 0);
        step("tdrain", 0, 0, 0, 0, 0, 0, 0, 0);
      end
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom % 3 == 0) ? a : (($urandom % 2) ? $urandom : a + 32'($urandom_range(0, 2)) - 32'd1);
      step("rand", ($urandom % 4) != 0, ($urandom % 3) == 0, int'($urandom % 8), a, b,
           ($urandom % 4) == 0, 1'($urandom), $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
